// File: rtl/rob_pkg.sv
// Shared types and default constants for the multi-port reorder buffer.
package rob_pkg;

  localparam int ROB_SIZE_DEF     = 8;
  localparam int ROB_XLEN_DEF     = 32;
  localparam int ROB_NUM_CDB_DEF  = 2;
  localparam int ROB_NUM_LOAD_DEF = 3;

  typedef enum logic [1:0] {
    ALU    = 2'd0,
    LOAD   = 2'd1,
    STORE  = 2'd2,
    BRANCH = 2'd3
  } iType_t;

  typedef struct packed {
    logic                    valid;
    logic                    ready;
    iType_t                  iType;
    logic [ROB_XLEN_DEF-1:0] value;
    logic [ROB_XLEN_DEF-1:0] dest;
  } rob_entry_t;

endpackage

// File: rtl/rob_load_check.sv
// Ordered older-store scan for one load port; store-to-load forwarding under ROB_STORE_FWD_EN.
module rob_load_check
  import rob_pkg::*;
#(
  parameter int  SIZE     = ROB_SIZE_DEF,
  parameter int  XLEN     = ROB_XLEN_DEF,
  localparam int PTR_SIZE = $clog2(SIZE)
) (
  input  logic [PTR_SIZE-1:0] head_ix_i,
  input  logic [SIZE-1:0]     valid_i,
  input  logic [SIZE-1:0]     ready_i,
  input  logic [SIZE-1:0]     is_store_i,
  input  logic [XLEN-1:0]     dest_i [SIZE],
`ifdef ROB_STORE_FWD_EN
  input  logic [XLEN-1:0]     value_i [SIZE],
  output logic                fwd_valid_o,
  output logic [XLEN-1:0]     fwd_data_o,
`endif
  input  logic                lb_valid_i,
  input  logic [PTR_SIZE-1:0] lb_rob_ix_i,
  input  logic [XLEN-1:0]     lb_addr_i,
  output logic                can_load_o
);

  logic [PTR_SIZE-1:0] age_ld_s;
  logic [PTR_SIZE-1:0] idx_s;
  logic                older_s;
  logic                blocked_s;
`ifdef ROB_STORE_FWD_EN
  logic                fwd_hit_s;
  logic                fwd_clean_s;
  logic [XLEN-1:0]     fwd_data_s;
`endif

  // Walk entries oldest-first; only stores older than the load can block it.
  always_comb begin
    age_ld_s  = lb_rob_ix_i - head_ix_i;
    idx_s     = head_ix_i;
    older_s   = 1'b0;
    blocked_s = 1'b0;
`ifdef ROB_STORE_FWD_EN
    fwd_hit_s   = 1'b0;
    fwd_clean_s = 1'b0;
    fwd_data_s  = {XLEN{1'b0}};
`endif
    for (int k = 0; k < SIZE; k++) begin
      idx_s     = head_ix_i + PTR_SIZE'(k);
      older_s   = (PTR_SIZE'(k) < age_ld_s) & valid_i[idx_s] & is_store_i[idx_s];
      blocked_s = blocked_s | (older_s & (~ready_i[idx_s] | (dest_i[idx_s] == lb_addr_i)));
`ifdef ROB_STORE_FWD_EN
      // A younger matching store replaces the candidate; any later unready store spoils it.
      fwd_hit_s   = fwd_hit_s | (older_s & ready_i[idx_s] & (dest_i[idx_s] == lb_addr_i));
      fwd_data_s  = (older_s & ready_i[idx_s] & (dest_i[idx_s] == lb_addr_i)) ?
                    value_i[idx_s] : fwd_data_s;
      fwd_clean_s = (older_s & ready_i[idx_s] & (dest_i[idx_s] == lb_addr_i)) ? 1'b1 :
                    ((older_s & ~ready_i[idx_s]) ? 1'b0 : fwd_clean_s);
`endif
    end
    can_load_o = lb_valid_i & ~blocked_s;
`ifdef ROB_STORE_FWD_EN
    fwd_valid_o = lb_valid_i & fwd_hit_s & fwd_clean_s;
    fwd_data_o  = fwd_data_s;
`endif
  end

endmodule

// File: rtl/rob_multiport_chk.sv
// Protocol checker for rob_multiport: no two CDB ports may target the same tag in one cycle.
module rob_multiport_chk #(
  parameter int NUM_CDB  = 2,
  parameter int PTR_SIZE = 3
) (
  input logic                               clk_i,
  input logic                               rst_n_i,
  input logic [NUM_CDB-1:0]                 cdb_valid_i,
  input logic [NUM_CDB-1:0][PTR_SIZE-1:0]   cdb_rob_ix_i
);

  function automatic logic cdb_collide(input logic [NUM_CDB-1:0] v,
                                       input logic [NUM_CDB-1:0][PTR_SIZE-1:0] ix);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < NUM_CDB; i++) begin
      for (int j = i + 1; j < NUM_CDB; j++) begin
        hit = hit | (v[i] & v[j] & (ix[i] == ix[j]));
      end
    end
    return hit;
  endfunction

  logic collide_s;

  // Duplicate-target detection across all CDB port pairs.
  always_comb begin
    collide_s = cdb_collide(cdb_valid_i, cdb_rob_ix_i);
  end

  a_cdb_unique_tag: assert property (@(posedge clk_i) disable iff (!rst_n_i) !collide_s);

endmodule

// File: rtl/rob_multiport.sv
// Parametrised circular reorder buffer: wrap-bit pointers, CDB bypass, load disambiguation,
// partial squash. Optional store-to-load forwarding ports under ROB_STORE_FWD_EN.
module rob_multiport
  import rob_pkg::*;
#(
  parameter int  SIZE     = ROB_SIZE_DEF,
  parameter int  XLEN     = ROB_XLEN_DEF,
  parameter int  NUM_CDB  = ROB_NUM_CDB_DEF,
  parameter int  NUM_LOAD = ROB_NUM_LOAD_DEF,
  localparam int PTR_SIZE = $clog2(SIZE)
) (
  input  logic                               clk_in,
  input  logic                               rst_n_in,
  input  logic [1:0][PTR_SIZE-1:0]           decode_rob_ix_in,
  output logic [1:0][XLEN-1:0]               decode_value_out,
  output logic [1:0]                         decode_ready_out,
  input  logic                               valid_in,
  input  iType_t                             iType_in,
  input  logic [XLEN-1:0]                    value_in,
  input  logic [XLEN-1:0]                    dest_in,
  output logic [PTR_SIZE-1:0]                inst_rob_ix_out,
  output logic                               ready_out,
  output logic [PTR_SIZE:0]                  count_out,
  input  logic [NUM_CDB-1:0]                 cdb_valid_in,
  input  logic [NUM_CDB-1:0][PTR_SIZE-1:0]   cdb_rob_ix_in,
  input  logic [NUM_CDB-1:0][XLEN-1:0]       cdb_value_in,
  input  logic [NUM_CDB-1:0][XLEN-1:0]       cdb_dest_in,
  input  logic [NUM_LOAD-1:0]                lb_valid_in,
  input  logic [NUM_LOAD-1:0][PTR_SIZE-1:0]  lb_rob_ix_in,
  input  logic [NUM_LOAD-1:0][XLEN-1:0]      lb_addr_in,
  output logic [NUM_LOAD-1:0]                can_load_out,
`ifdef ROB_STORE_FWD_EN
  output logic [NUM_LOAD-1:0]                load_fwd_valid_out,
  output logic [NUM_LOAD-1:0][XLEN-1:0]      load_fwd_data_out,
`endif
  output logic [PTR_SIZE-1:0]                ix_out,
  output iType_t                             iType_out,
  output logic [XLEN-1:0]                    value_out,
  output logic [XLEN-1:0]                    dest_out,
  output logic                               commit_out,
  output logic                               store_valid_out,
  input  logic                               store_read_in,
  input  logic                               flush_in,
  input  logic [PTR_SIZE-1:0]                flush_ix_in
);

  localparam logic [PTR_SIZE:0] FULL_CNT = (PTR_SIZE+1)'(SIZE);

  logic [PTR_SIZE:0]   head_q, head_d, tail_q, tail_d, count_s;
  logic [SIZE-1:0]     valid_q, valid_d, ready_q, ready_d, keep_s, is_store_s;
  iType_t              itype_q [SIZE];
  iType_t              itype_d [SIZE];
  logic [XLEN-1:0]     value_q [SIZE];
  logic [XLEN-1:0]     value_d [SIZE];
  logic [XLEN-1:0]     dest_q  [SIZE];
  logic [XLEN-1:0]     dest_d  [SIZE];
  logic [PTR_SIZE-1:0] head_ix_s, tail_ix_s, flush_dist_s;
  logic                empty_s, full_s, head_rdy_s, pop_s, flush_ok_s, alloc_s;

  assign head_ix_s = head_q[PTR_SIZE-1:0];
  assign tail_ix_s = tail_q[PTR_SIZE-1:0];
  assign count_s   = tail_q - head_q;
  assign empty_s   = (count_s == {(PTR_SIZE+1){1'b0}});
  assign full_s    = (count_s == FULL_CNT);

  assign ready_out       = ~full_s;
  assign count_out       = count_s;
  assign inst_rob_ix_out = tail_ix_s;
  assign ix_out          = head_ix_s;
  assign iType_out       = itype_q[head_ix_s];
  assign value_out       = value_q[head_ix_s];
  assign dest_out        = dest_q[head_ix_s];

  assign head_rdy_s      = ~empty_s & ready_q[head_ix_s];
  assign commit_out      = head_rdy_s & (itype_q[head_ix_s] != STORE);
  assign store_valid_out = head_rdy_s & (itype_q[head_ix_s] == STORE);
  assign pop_s           = commit_out | (store_valid_out & store_read_in);

  // A flush naming a free slot is ignored; an accepted flush wins over allocation.
  assign flush_ok_s   = flush_in & valid_q[flush_ix_in];
  assign flush_dist_s = flush_ix_in - head_ix_s;
  assign alloc_s      = valid_in & ~full_s & ~flush_ok_s;

  // Survivor mask by age relative to head, plus the store-type vector for load checks.
  always_comb begin
    keep_s     = {SIZE{1'b1}};
    is_store_s = {SIZE{1'b0}};
    for (int i = 0; i < SIZE; i++) begin
      keep_s[i]     = ~flush_ok_s | ((PTR_SIZE'(i) - head_ix_s) <= flush_dist_s);
      is_store_s[i] = (itype_q[i] == STORE);
    end
  end

  // Entry next-state: squash, CDB writes to live entries (higher port wins), pop, allocate.
  always_comb begin
    valid_d = valid_q & keep_s;
    ready_d = ready_q;
    itype_d = itype_q;
    value_d = value_q;
    dest_d  = dest_q;
    for (int p = 0; p < NUM_CDB; p++) begin
      value_d[cdb_rob_ix_in[p]] = (cdb_valid_in[p] & valid_d[cdb_rob_ix_in[p]]) ?
                                  cdb_value_in[p] : value_d[cdb_rob_ix_in[p]];
      dest_d[cdb_rob_ix_in[p]]  = (cdb_valid_in[p] & valid_d[cdb_rob_ix_in[p]] &
                                   (itype_q[cdb_rob_ix_in[p]] == STORE)) ?
                                  dest_q[cdb_rob_ix_in[p]] + cdb_dest_in[p] :
                                  dest_d[cdb_rob_ix_in[p]];
      ready_d[cdb_rob_ix_in[p]] = ready_d[cdb_rob_ix_in[p]] |
                                  (cdb_valid_in[p] & valid_d[cdb_rob_ix_in[p]]);
    end
    valid_d[head_ix_s] = valid_d[head_ix_s] & ~pop_s;
    valid_d[tail_ix_s] = valid_d[tail_ix_s] | alloc_s;
    ready_d[tail_ix_s] = ready_d[tail_ix_s] & ~alloc_s;
    itype_d[tail_ix_s] = alloc_s ? iType_in : itype_d[tail_ix_s];
    value_d[tail_ix_s] = alloc_s ? value_in : value_d[tail_ix_s];
    dest_d[tail_ix_s]  = alloc_s ? dest_in  : dest_d[tail_ix_s];
    head_d = head_q + {{PTR_SIZE{1'b0}}, pop_s};
    tail_d = flush_ok_s ? (head_q + {1'b0, flush_dist_s} + {{PTR_SIZE{1'b0}}, 1'b1}) :
                          (tail_q + {{PTR_SIZE{1'b0}}, alloc_s});
  end

  // Pointer and entry storage.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      head_q  <= {(PTR_SIZE+1){1'b0}};
      tail_q  <= {(PTR_SIZE+1){1'b0}};
      valid_q <= {SIZE{1'b0}};
      ready_q <= {SIZE{1'b0}};
      for (int i = 0; i < SIZE; i++) begin
        itype_q[i] <= ALU;
        value_q[i] <= {XLEN{1'b0}};
        dest_q[i]  <= {XLEN{1'b0}};
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
      itype_q <= itype_d;
      value_q <= value_d;
      dest_q  <= dest_d;
    end
  end

  // Operand lookup with same-cycle CDB bypass.
  always_comb begin
    for (int d = 0; d < 2; d++) begin
      decode_value_out[d] = value_q[decode_rob_ix_in[d]];
      decode_ready_out[d] = ready_q[decode_rob_ix_in[d]];
      for (int p = 0; p < NUM_CDB; p++) begin
        decode_value_out[d] = (cdb_valid_in[p] & valid_q[decode_rob_ix_in[d]] &
                               (cdb_rob_ix_in[p] == decode_rob_ix_in[d])) ?
                              cdb_value_in[p] : decode_value_out[d];
        decode_ready_out[d] = decode_ready_out[d] |
                              (cdb_valid_in[p] & valid_q[decode_rob_ix_in[d]] &
                               (cdb_rob_ix_in[p] == decode_rob_ix_in[d]));
      end
    end
  end

  for (genvar l = 0; l < NUM_LOAD; l++) begin : g_load
    rob_load_check #(.SIZE(SIZE), .XLEN(XLEN)) u_load_check (
      .head_ix_i   (head_ix_s),
      .valid_i     (valid_q),
      .ready_i     (ready_q),
      .is_store_i  (is_store_s),
      .dest_i      (dest_q),
`ifdef ROB_STORE_FWD_EN
      .value_i     (value_q),
      .fwd_valid_o (load_fwd_valid_out[l]),
      .fwd_data_o  (load_fwd_data_out[l]),
`endif
      .lb_valid_i  (lb_valid_in[l]),
      .lb_rob_ix_i (lb_rob_ix_in[l]),
      .lb_addr_i   (lb_addr_in[l]),
      .can_load_o  (can_load_out[l])
    );
  end

  rob_multiport_chk #(.NUM_CDB(NUM_CDB), .PTR_SIZE(PTR_SIZE)) u_chk (
    .clk_i        (clk_in),
    .rst_n_i      (rst_n_in),
    .cdb_valid_i  (cdb_valid_in),
    .cdb_rob_ix_i (cdb_rob_ix_in)
  );

endmodule

// File: tb/tb_rob_multiport.sv
// Scoreboard bench for rob_multiport: queue-based ROB reference model, directed scenarios, random traffic.
module tb_rob_multiport;
  import rob_pkg::*;

  localparam int SIZE = 8;
  localparam int XLEN = 32;
  localparam int NC   = 2;
  localparam int NL   = 3;
  localparam int P    = 3;

  logic                    clk_in = 1'b0;
  logic                    rst_n_in;
  logic [1:0][P-1:0]       decode_rob_ix_in;
  logic [1:0][XLEN-1:0]    decode_value_out;
  logic [1:0]              decode_ready_out;
  logic                    valid_in;
  iType_t                  iType_in;
  logic [XLEN-1:0]         value_in, dest_in;
  logic [P-1:0]            inst_rob_ix_out;
  logic                    ready_out;
  logic [P:0]              count_out;
  logic [NC-1:0]           cdb_valid_in;
  logic [NC-1:0][P-1:0]    cdb_rob_ix_in;
  logic [NC-1:0][XLEN-1:0] cdb_value_in, cdb_dest_in;
  logic [NL-1:0]           lb_valid_in;
  logic [NL-1:0][P-1:0]    lb_rob_ix_in;
  logic [NL-1:0][XLEN-1:0] lb_addr_in;
  logic [NL-1:0]           can_load_out;
`ifdef ROB_STORE_FWD_EN
  logic [NL-1:0]           load_fwd_valid_out;
  logic [NL-1:0][XLEN-1:0] load_fwd_data_out;
`endif
  logic [P-1:0]            ix_out;
  iType_t                  iType_out;
  logic [XLEN-1:0]         value_out, dest_out;
  logic                    commit_out, store_valid_out, store_read_in, flush_in;
  logic [P-1:0]            flush_ix_in;

  always #5 clk_in = ~clk_in;

  rob_multiport #(.SIZE(SIZE), .XLEN(XLEN), .NUM_CDB(NC), .NUM_LOAD(NL)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in),
    .decode_rob_ix_in(decode_rob_ix_in), .decode_value_out(decode_value_out),
    .decode_ready_out(decode_ready_out), .valid_in(valid_in), .iType_in(iType_in),
    .value_in(value_in), .dest_in(dest_in), .inst_rob_ix_out(inst_rob_ix_out),
    .ready_out(ready_out), .count_out(count_out), .cdb_valid_in(cdb_valid_in),
    .cdb_rob_ix_in(cdb_rob_ix_in), .cdb_value_in(cdb_value_in), .cdb_dest_in(cdb_dest_in),
    .lb_valid_in(lb_valid_in), .lb_rob_ix_in(lb_rob_ix_in), .lb_addr_in(lb_addr_in),
    .can_load_out(can_load_out),
`ifdef ROB_STORE_FWD_EN
    .load_fwd_valid_out(load_fwd_valid_out), .load_fwd_data_out(load_fwd_data_out),
`endif
    .ix_out(ix_out), .iType_out(iType_out), .value_out(value_out), .dest_out(dest_out),
    .commit_out(commit_out), .store_valid_out(store_valid_out),
    .store_read_in(store_read_in), .flush_in(flush_in), .flush_ix_in(flush_ix_in)
  );

  // Reference model: in-order list of live instructions, oldest first.
  typedef struct { iType_t t; logic [31:0] v; logic [31:0] d; bit r; } ment_t;
  typedef struct { int ix; iType_t t; logic [31:0] v; logic [31:0] d; } exp_t;
  ment_t m_q[$];
  exp_t  exp_q[$];
  int    hd = 0;
  int    total = 0;
  int    bad = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic int pos_of(input int tag);
    return ((tag - hd) % SIZE + SIZE) % SIZE;
  endfunction

  task automatic idle();
    valid_in = 1'b0; iType_in = ALU; value_in = '0; dest_in = '0;
    cdb_valid_in = '0; cdb_rob_ix_in = '0; cdb_value_in = '0; cdb_dest_in = '0;
    lb_valid_in = '0; lb_rob_ix_in = '0; lb_addr_in = '0;
    decode_rob_ix_in = '0; store_read_in = 1'b0; flush_in = 1'b0; flush_ix_in = '0;
  endtask

  task automatic check_comb();
    int n, pos, t;
    logic [31:0] ev;
    logic er, cl, ecommit, estore;
    n = m_q.size();
    chk("count", count_out, n);
    chk("ready", ready_out, n < SIZE);
    chk("inst_ix", inst_rob_ix_out, (hd + n) % SIZE);
    ecommit = (n > 0) && m_q[0].r && (m_q[0].t != STORE);
    estore  = (n > 0) && m_q[0].r && (m_q[0].t == STORE);
    chk("commit", commit_out, ecommit);
    chk("store_valid", store_valid_out, estore);
    if (n > 0) begin
      chk("head_ix", ix_out, hd);
      chk("head_value", value_out, m_q[0].v);
      chk("head_dest", dest_out, m_q[0].d);
    end
    for (int d = 0; d < 2; d++) begin
      t = decode_rob_ix_in[d];
      pos = pos_of(t);
      if (pos < n) begin
        ev = m_q[pos].v; er = m_q[pos].r;
        for (int p = 0; p < NC; p++)
          if (cdb_valid_in[p] && cdb_rob_ix_in[p] == t) begin ev = cdb_value_in[p]; er = 1'b1; end
        chk("dec_value", decode_value_out[d], ev);
        chk("dec_ready", decode_ready_out[d], er);
      end
    end
    for (int l = 0; l < NL; l++) begin
      cl = lb_valid_in[l];
      pos = pos_of(lb_rob_ix_in[l]);
      for (int k = 0; k < pos && k < n; k++)
        if (m_q[k].t == STORE && (!m_q[k].r || m_q[k].d == lb_addr_in[l])) cl = 1'b0;
      if (!lb_valid_in[l]) cl = 1'b0;
      chk("can_load", can_load_out[l], cl);
    end
  endtask

  task automatic model_step();
    int n, keep, pos;
    bit pop, fl;
    n = m_q.size();
    pop = (n > 0) && m_q[0].r && (m_q[0].t != STORE || store_read_in);
    if (pop) exp_q.push_back('{hd, m_q[0].t, m_q[0].v, m_q[0].d});
    pos = pos_of(flush_ix_in);
    fl = flush_in && (pos < n);
    keep = fl ? pos + 1 : n;
    for (int p = 0; p < NC; p++) begin
      pos = pos_of(cdb_rob_ix_in[p]);
      if (cdb_valid_in[p] && pos < keep) begin
        m_q[pos].v = cdb_value_in[p];
        m_q[pos].r = 1'b1;
        if (m_q[pos].t == STORE) m_q[pos].d = m_q[pos].d + cdb_dest_in[p];
      end
    end
    while (m_q.size() > keep) void'(m_q.pop_back());
    if (pop) begin void'(m_q.pop_front()); hd = (hd + 1) % SIZE; end
    if (valid_in && n < SIZE && !fl) m_q.push_back('{iType_in, value_in, dest_in, 1'b0});
  endtask

  task automatic step();
    @(negedge clk_in);
    check_comb();
    model_step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst_n_in = 1'b0;
    m_q.delete(); exp_q.delete(); hd = 0;
    #1;
    chk("rst_count", count_out, 0);
    chk("rst_ready", ready_out, 1);
    chk("rst_inst_ix", inst_rob_ix_out, 0);
    chk("rst_commit", commit_out, 0);
    chk("rst_store_valid", store_valid_out, 0);
    chk("rst_can_load", can_load_out, 0);
    chk("rst_dec_ready", decode_ready_out, 0);
    @(posedge clk_in); #1;
    rst_n_in = 1'b1;
  endtask

  task automatic alloc(input iType_t t, input logic [31:0] v, input logic [31:0] d);
    valid_in = 1'b1; iType_in = t; value_in = v; dest_in = d;
    step();
    valid_in = 1'b0;
  endtask

  // Monitor: every pop the DUT presents must match the oldest expected retirement.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_in);
      #2;
      if (rst_n_in && (commit_out || (store_valid_out && store_read_in))) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL pop_unexpected: got pop of tag %0d expected none", ix_out);
        end else begin
          e = exp_q.pop_front();
          chk("pop_ix", ix_out, e.ix);
          chk("pop_type", iType_out, e.t);
          chk("pop_value", value_out, e.v);
          chk("pop_dest", dest_out, e.d);
        end
      end
    end
  end

  initial begin
    int n, tg;
    rst_n_in = 1'b0;
    idle();
    @(posedge clk_in); #1;
    do_reset();

    // Fill to full, refuse a ninth, retire tag 0.
    for (int i = 0; i < 8; i++) alloc(ALU, 32'(i + 16), 32'(i));
    chk("full_count", count_out, 8);
    chk("full_ready", ready_out, 0);
    alloc(ALU, 32'h99, 32'h9);
    chk("full_refuse", count_out, 8);
    cdb_valid_in[0] = 1'b1; cdb_rob_ix_in[0] = 3'd0; cdb_value_in[0] = 32'd5;
    step(); idle();
    chk("commit_hi", commit_out, 1);
    chk("commit_val", value_out, 5);
    step();
    chk("ready_after_pop", ready_out, 1);

    // Store address update, load disambiguation, held store handshake.
    do_reset();
    alloc(ALU, 32'h1, 32'h1);
    alloc(STORE, 32'h0, 32'h100);
    alloc(ALU, 32'h2, 32'h2);
    alloc(LOAD, 32'h3, 32'h3);
    lb_valid_in[0] = 1'b1; lb_rob_ix_in[0] = 3'd3; lb_addr_in[0] = 32'h104;
    #1 chk("ld_unready_store", can_load_out[0], 0);
    cdb_valid_in[0] = 1'b1; cdb_rob_ix_in[0] = 3'd1; cdb_value_in[0] = 32'hAA; cdb_dest_in[0] = 32'h4;
    step();
    cdb_valid_in = '0;
    #1 chk("ld_same_addr", can_load_out[0], 0);
    lb_addr_in[0] = 32'h200;
    #1 chk("ld_diff_addr", can_load_out[0], 1);
    cdb_valid_in[1] = 1'b1; cdb_rob_ix_in[1] = 3'd0; cdb_value_in[1] = 32'h11;
    step(); cdb_valid_in = '0;
    step();
    chk("st_valid", store_valid_out, 1);
    chk("st_dest", dest_out, 32'h104);
    step();
    chk("st_held", store_valid_out, 1);
    store_read_in = 1'b1;
    step(); store_read_in = 1'b0;
    chk("st_head_adv", ix_out, 2);

    // Partial squash.
    do_reset();
    for (int i = 0; i < 6; i++) alloc(BRANCH, 32'(i), 32'(i));
    flush_in = 1'b1; flush_ix_in = 3'd2;
    step(); idle();
    chk("flush_count", count_out, 3);
    chk("flush_inst_ix", inst_rob_ix_out, 3);
    cdb_valid_in[0] = 1'b1; cdb_rob_ix_in[0] = 3'd4; cdb_value_in[0] = 32'h77;
    step(); idle();
    alloc(ALU, 32'h30, 32'h0);
    alloc(ALU, 32'h40, 32'h0);
    decode_rob_ix_in[0] = 3'd4;
    #1 chk("squash_cdb_drop", decode_ready_out[0], 0);

    // Wrap-around with decode bypass.
    do_reset();
    for (int i = 0; i < 6; i++) alloc(ALU, 32'(i), 32'(i));
    for (int c = 0; c < 8; c++) begin
      valid_in = 1'b1; iType_in = ALU; value_in = 32'(c + 100); dest_in = 32'(c);
      cdb_valid_in = (c < 3) ? 2'b11 : 2'b00;
      cdb_rob_ix_in[0] = 3'(2 * c); cdb_rob_ix_in[1] = 3'(2 * c + 1);
      cdb_value_in[0] = 32'(c + 200); cdb_value_in[1] = 32'(c + 300);
      step();
    end
    idle();
    decode_rob_ix_in[0] = 3'd7;
    cdb_valid_in[1] = 1'b1; cdb_rob_ix_in[1] = 3'd7; cdb_value_in[1] = 32'hBEEF;
    #1 chk("bypass_value", decode_value_out[0], 32'hBEEF);
    chk("bypass_ready", decode_ready_out[0], 1);
    step(); idle();

    // Asynchronous reset mid-run.
    do_reset();
    for (int i = 0; i < 5; i++) alloc(ALU, 32'(i), 32'(i));
    #2;
    rst_n_in = 1'b0;
    m_q.delete(); exp_q.delete(); hd = 0;
    #1;
    chk("async_count", count_out, 0);
    chk("async_ready", ready_out, 1);
    chk("async_inst_ix", inst_rob_ix_out, 0);
    @(posedge clk_in); #1;
    rst_n_in = 1'b1;

    // Randomised traffic against the model.
    for (int c = 0; c < 1500; c++) begin
      idle();
      n = m_q.size();
      valid_in = ($urandom_range(0, 9) < 6);
      iType_in = iType_t'($urandom_range(0, 3));
      value_in = $urandom;
      dest_in = 32'h100 + 32'(4 * $urandom_range(0, 2));
      for (int p = 0; p < NC; p++) begin
        cdb_valid_in[p] = ($urandom_range(0, 2) != 0);
        tg = (n > 0 && $urandom_range(0, 3) != 0) ? (hd + $urandom_range(0, n - 1)) % SIZE
                                                  : $urandom_range(0, SIZE - 1);
        cdb_rob_ix_in[p] = 3'(tg);
        cdb_value_in[p] = $urandom;
        cdb_dest_in[p] = 32'(4 * $urandom_range(0, 1));
      end
      if (cdb_valid_in[0] && cdb_valid_in[1] && cdb_rob_ix_in[0] == cdb_rob_ix_in[1])
        cdb_rob_ix_in[1] = cdb_rob_ix_in[0] + 3'd1;
      for (int l = 0; l < NL; l++) begin
        lb_valid_in[l] = ($urandom_range(0, 3) != 0);
        lb_rob_ix_in[l] = 3'($urandom_range(0, SIZE - 1));
        lb_addr_in[l] = 32'h100 + 32'(4 * $urandom_range(0, 4));
      end
      decode_rob_ix_in[0] = 3'($urandom_range(0, SIZE - 1));
      decode_rob_ix_in[1] = 3'($urandom_range(0, SIZE - 1));
      store_read_in = $urandom_range(0, 1);
      flush_in = ($urandom_range(0, 24) == 0);
      flush_ix_in = 3'($urandom_range(0, SIZE - 1));
      step();
    end
    idle();
    step();
    chk("sb_drain", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
